// File: rtl/arrow_spawn_scheduler.sv
// rtl/arrow_spawn_scheduler.sv - run-state FSM, tempo-ramped lane spawner and fall-speed publisher
// Optional per-lane spacing counters are compiled in with `define ARROW_SCHED_LANE_GAP_EN.
module arrow_spawn_scheduler #(
    parameter int BASE_PERIOD      = 200,
    parameter int MIN_PERIOD       = 40,
    parameter int PERIOD_STEP      = 4,
    parameter int LANE_GAP         = 20,
    parameter int COUNTDOWN_FRAMES = 120
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic        start,
    input  logic        stop,
    input  logic        pause,
    input  logic [4:0]  rand_bits,
    input  logic [10:0] score,
    input  logic [3:0]  lane_free,
    output logic        spawn_valid,
    output logic [1:0]  spawn_lane,
    input  logic        spawn_ready,
    output logic [2:0]  speed,
    output logic [1:0]  state,
    output logic [7:0]  skip_count
);

    typedef enum logic [1:0] {S_IDLE, S_COUNTDOWN, S_RUN, S_PAUSED} state_t;

    localparam logic [15:0] BASE16 = 16'(BASE_PERIOD);
    localparam logic [15:0] MIN16  = 16'(MIN_PERIOD);
    localparam logic [15:0] CD16   = 16'(COUNTDOWN_FRAMES);

    state_t      st, st_nxt;
    logic [15:0] frame_cnt, cnt_inc, ramp, period;
    logic [3:0]  eligible;
    logic [1:0]  pick, idx;
    logic        found, xfer;
    logic [2:0]  speed_calc;
    logic        unused_rand;

    assign state       = st;
    assign cnt_inc     = frame_cnt + 16'd1;
    assign ramp        = {5'd0, score} * 16'(PERIOD_STEP);
    assign period      = (ramp > BASE16 || (BASE16 - ramp) < MIN16) ? MIN16 : BASE16 - ramp;
    assign xfer        = spawn_valid && spawn_ready && !stop;
    assign unused_rand = ^rand_bits[4:2];

    always_comb begin
        if (score <= 11'd5)       speed_calc = 3'd1;
        else if (score <= 11'd10) speed_calc = 3'd2;
        else if (score <= 11'd15) speed_calc = 3'd3;
        else if (score <= 11'd20) speed_calc = 3'd4;
        else                      speed_calc = 3'd5;
    end

    // Walk the search order backwards so the highest-priority eligible lane lands last.
    always_comb begin
        found = 1'b0;
        pick  = rand_bits[1:0];
        idx   = rand_bits[1:0];
        for (int k = 3; k >= 0; k--) begin
            idx = rand_bits[1:0] + 2'(k);
            if (eligible[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

`ifdef ARROW_SCHED_LANE_GAP_EN
    localparam int GW = $clog2(LANE_GAP + 1);
    logic [GW-1:0] gap [4];

    always_comb begin
        for (int i = 0; i < 4; i++)
            eligible[i] = lane_free[i] && (gap[i] == '0);
    end

    always_ff @(posedge clk) begin
        if (reset || (st == S_IDLE && st_nxt == S_COUNTDOWN)) begin
            for (int i = 0; i < 4; i++) gap[i] <= '0;
        end else if (st == S_RUN) begin
            for (int i = 0; i < 4; i++) begin
                if (xfer && spawn_lane == 2'(i))
                    gap[i] <= GW'(LANE_GAP);
                else if (frame_tick && gap[i] != '0)
                    gap[i] <= gap[i] - 1'b1;
            end
        end
    end
`else
    localparam int unused_lane_gap = LANE_GAP;
    assign eligible = lane_free;
`endif

    always_ff @(posedge clk) begin
        if (reset) st <= S_IDLE;
        else       st <= st_nxt;
    end

    always_comb begin
        st_nxt = st;
        if (stop) begin
            st_nxt = S_IDLE;
        end else begin
            case (st)
                S_IDLE:      if (start) st_nxt = S_COUNTDOWN;
                S_COUNTDOWN: if (frame_tick && cnt_inc >= CD16) st_nxt = S_RUN;
                S_RUN:       if (pause && !spawn_valid) st_nxt = S_PAUSED;
                S_PAUSED:    if (!pause) st_nxt = S_RUN;
                default:     st_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt   <= '0;
            spawn_valid <= 1'b0;
            spawn_lane  <= 2'd0;
            speed       <= 3'd1;
            skip_count  <= 8'd0;
        end else begin
            if (frame_tick) speed <= speed_calc;
            if (stop) begin
                spawn_valid <= 1'b0;
            end else begin
                case (st)
                    S_IDLE: if (start) begin
                        frame_cnt   <= '0;
                        skip_count  <= 8'd0;
                        spawn_valid <= 1'b0;
                    end
                    S_COUNTDOWN: if (frame_tick)
                        frame_cnt <= (cnt_inc >= CD16) ? 16'd0 : cnt_inc;
                    S_RUN: begin
                        // A pending request freezes the frame counter until it is accepted.
                        if (spawn_valid) begin
                            if (spawn_ready) spawn_valid <= 1'b0;
                        end else if (frame_tick && !pause) begin
                            if (cnt_inc >= period) begin
                                frame_cnt <= '0;
                                if (found) begin
                                    spawn_valid <= 1'b1;
                                    spawn_lane  <= pick;
                                end else if (skip_count != 8'hFF) begin
                                    skip_count <= skip_count + 8'd1;
                                end
                            end else begin
                                frame_cnt <= cnt_inc;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_arrow_spawn_scheduler.sv
// tb/tb_arrow_spawn_scheduler.sv - scoreboard bench for arrow_spawn_scheduler
module tb_arrow_spawn_scheduler;

    localparam int GAP = 60;
`ifdef ARROW_SCHED_LANE_GAP_EN
    localparam int SECOND_LANE = 1;
`else
    localparam int SECOND_LANE = 0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_tick = 1'b0, start = 1'b0, stop = 1'b0, pause = 1'b0;
    logic [4:0]  rand_bits = 5'd0;
    logic [10:0] score = 11'd0;
    logic [3:0]  lane_free = 4'hF;
    logic        spawn_ready = 1'b1;
    logic        spawn_valid;
    logic [1:0]  spawn_lane;
    logic [2:0]  speed;
    logic [1:0]  state;
    logic [7:0]  skip_count;

    int tests = 0, fails = 0;
    int valid_ticks = 0;
    logic       last_valid;
    logic [1:0] last_lane;
    int exp_q[$];

    arrow_spawn_scheduler #(.LANE_GAP(GAP)) dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start), .stop(stop),
        .pause(pause), .rand_bits(rand_bits), .score(score), .lane_free(lane_free),
        .spawn_valid(spawn_valid), .spawn_lane(spawn_lane), .spawn_ready(spawn_ready),
        .speed(speed), .state(state), .skip_count(skip_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && spawn_valid && spawn_ready && !stop) begin
            if (exp_q.size() == 0) check("spawn_unexpected", 32'(spawn_lane), 32'hFFFF);
            else                   check("spawn_lane", 32'(spawn_lane), 32'(exp_q.pop_front()));
        end
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        last_valid = spawn_valid;
        last_lane  = spawn_lane;
        if (spawn_valid) valid_ticks++;
        cyc();
    endtask

    task automatic run_ticks(input int n);
        valid_ticks = 0;
        repeat (n) tick();
    endtask

    int sc_tab[8] = '{5, 6, 10, 11, 16, 20, 21, 0};
    int sp_tab[8] = '{1, 2, 2, 3, 4, 4, 5, 1};

    initial begin
        repeat (3) cyc();
        reset = 1'b0;
        check("rst_state", 32'(state), 0);
        check("rst_valid", 32'(spawn_valid), 0);
        check("rst_lane", 32'(spawn_lane), 0);
        check("rst_speed", 32'(speed), 1);
        check("rst_skip", 32'(skip_count), 0);

        for (int i = 0; i < 8; i++) begin
            score = 11'(sc_tab[i]);
            tick();
            check("speed_idle", 32'(speed), 32'(sp_tab[i]));
        end
        check("idle_no_spawn", 32'(state), 0);

        start = 1'b1; cyc(); start = 1'b0;
        check("cd_enter", 32'(state), 1);
        run_ticks(119);
        check("cd_119", 32'(state), 1);
        tick();
        check("cd_120_run", 32'(state), 2);
        check("cd_speed", 32'(speed), 1);

        for (int p = 0; p < 2; p++) begin
            exp_q.push_back(0);
            run_ticks(200);
            check("p200_count", 32'(valid_ticks), 1);
            check("p200_latency", 32'(last_valid), 1);
            check("p200_done", 32'(spawn_valid), 0);
        end

        score = 11'd100; rand_bits = 5'd0; exp_q.push_back(0);
        run_ticks(39);
        check("p40_early", 32'(valid_ticks), 0);
        tick();
        check("p40_hit", 32'(last_valid), 1);
        check("speed_100", 32'(speed), 5);

        score = 11'd40; rand_bits = 5'd1; exp_q.push_back(1);
        run_ticks(40);
        check("s40_count", 32'(valid_ticks), 1);
        check("s40_last", 32'(last_valid), 1);

        score = 11'd39; rand_bits = 5'd2; exp_q.push_back(2);
        run_ticks(43);
        check("s39_early", 32'(valid_ticks), 0);
        tick();
        check("s39_hit", 32'(last_valid), 1);

        score = 11'd100; rand_bits = 5'd2; lane_free = 4'b1011; exp_q.push_back(3);
        run_ticks(40);
        check("sel_valid", 32'(last_valid), 1);
        check("sel_lane", 32'(last_lane), 3);

        lane_free = 4'b0000;
        run_ticks(40);
        check("skip_one", 32'(skip_count), 1);
        check("skip_novalid", 32'(valid_ticks), 0);
        run_ticks(253 * 40);
        check("skip_254", 32'(skip_count), 254);
        run_ticks(46 * 40);
        check("skip_sat", 32'(skip_count), 255);

        lane_free = 4'hF; rand_bits = 5'd1; spawn_ready = 1'b0; exp_q.push_back(1);
        run_ticks(40);
        check("stall_valid", 32'(last_valid), 1);
        for (int i = 0; i < 50; i++) begin
            if (i == 10) pause = 1'b1;
            frame_tick = (i % 2 == 0);
            cyc();
            check("stall_valid_hold", 32'(spawn_valid), 1);
            check("stall_lane_hold", 32'(spawn_lane), 1);
            check("stall_state_run", 32'(state), 2);
        end
        frame_tick = 1'b0; spawn_ready = 1'b1;
        cyc();
        check("xfer_valid_low", 32'(spawn_valid), 0);
        check("xfer_state_run", 32'(state), 2);
        cyc();
        check("paused", 32'(state), 3);
        pause = 1'b0;
        cyc();
        check("resumed", 32'(state), 2);

        rand_bits = 5'd0; exp_q.push_back(0);
        run_ticks(40);
        check("gap_first", 32'(last_lane), 0);
        exp_q.push_back(SECOND_LANE);
        run_ticks(40);
        check("gap_second", 32'(last_lane), 32'(SECOND_LANE));

        spawn_ready = 1'b0; rand_bits = 5'd2;
        run_ticks(40);
        check("stop_pending", 32'(last_valid), 1);
        stop = 1'b1; spawn_ready = 1'b1; cyc(); stop = 1'b0;
        check("stop_valid", 32'(spawn_valid), 0);
        check("stop_state", 32'(state), 0);
        repeat (3) cyc();
        start = 1'b1; cyc(); start = 1'b0;
        check("restart_state", 32'(state), 1);
        check("restart_skip", 32'(skip_count), 0);

        check("queue_drained", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/arrow_spawn_scheduler.md
# arrow_spawn_scheduler

Frame-rate scheduler sitting in front of the arrow playfield renderer. It owns the game run state (idle, countdown, run, pause). It decides when a new arrow is spawned and in which of the four lanes (U, D, L, R), applying a score-driven tempo ramp and per-lane spacing rules. Spawns are delivered to the playfield datapath over a valid/ready handshake. It also publishes the arrow fall speed.

## Interface
Parameters:
- `BASE_PERIOD`, 200: frames between spawns at score 0.
- `MIN_PERIOD`, 40: floor on the spawn period.
- `PERIOD_STEP`, 4: frames removed from the period per score point.
- `LANE_GAP`, 20: minimum frames between two spawns in the same lane.
- `COUNTDOWN_FRAMES`, 120: frames spent in COUNTDOWN before RUN.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `frame_tick` in 1: one-cycle pulse per video frame.
- `start` in 1: pulse; leave IDLE.
- `stop` in 1: pulse; return to IDLE from any state.
- `pause` in 1: level; freeze play while high.
- `rand` in 5: LFSR value; bits [1:0] seed the lane choice.
- `score` in 11: current score, unsigned.
- `lane_free` in 4: bit n=1 means the playfield has a free arrow slot in lane n (0=U, 1=D, 2=L, 3=R).
- `spawn_valid` out 1: spawn request pending.
- `spawn_lane` out 2: lane of the pending request.
- `spawn_ready` in 1: playfield accepts the request this cycle.
- `speed` out 3: fall speed in pixels/frame, range 1..5.
- `state` out 2: 0=IDLE, 1=COUNTDOWN, 2=RUN, 3=PAUSED.
- `skip_count` out 8: spawns dropped because no lane was eligible; saturates at 255.

## Operation
FSM transitions:
- IDLE→COUNTDOWN on `start`.
- COUNTDOWN→RUN after `COUNTDOWN_FRAMES` ticks.
- RUN→PAUSED when `pause`=1 and no spawn is pending.
- PAUSED→RUN when `pause`=0.
- Any state→IDLE on `stop`. `stop` beats `start`/`pause`; `start` is ignored outside IDLE.

Entering COUNTDOWN clears the frame counter, gap counters, `skip_count` and any pending request.

Period:
- Computed in 16-bit unsigned: `period = BASE_PERIOD - score*PERIOD_STEP`.
- Clamped to `MIN_PERIOD` if the subtraction underflows or the result is below `MIN_PERIOD`.
- Sampled on each tick.

Spawn cycle (RUN, no request pending, `frame_tick`=1):
- Increment the frame counter.
- If the new value ≥ `period`: clear the counter and select a lane.
- Selection search order: `rand[1:0]`, then +1, +2, +3 mod 4. The first lane with `lane_free`=1 and gap counter=0 wins.
- If no lane is eligible: increment `skip_count` (saturating) and issue no request.

Handshake:
- `spawn_valid` stays high and `spawn_lane` stays stable until the cycle where `spawn_valid`&&`spawn_ready`. `spawn_valid` deasserts on the next edge.
- The request is never retracted, except by `stop` or `reset`.
- The frame counter holds at 0 while a request is pending.
- On transfer, the winning lane's gap counter loads `LANE_GAP`.

Gap counters:
- Decrement on each tick in RUN, saturating at 0.
- Frozen in PAUSED and COUNTDOWN.

Speed, registered on each tick in any state:
- 1 if score ≤5.
- 2 if score is 6..10.
- 3 if score is 11..15.
- 4 if score is 16..20.
- 5 if score >20.

## Timing
- Reset values: `state`=IDLE, `spawn_valid`=0, `spawn_lane`=0, `speed`=1, `skip_count`=0. All counters are 0.
- Latency: `spawn_valid` rises on the edge after the `frame_tick` cycle that reaches the period (1 cycle).
- `frame_tick` and `spawn_ready` in the same cycle: both take effect. The counter still holds, because the request was pending at that edge.
- `pause` rising while a request is pending: PAUSED is entered on the edge after the transfer.
- `reset` or `stop` mid-request: `spawn_valid`=0 after the next edge. No transfer is counted.
- Lane search is combinational from the registered gap counters and the live `lane_free`/`rand`.

## Configuration
- `ARROW_SCHED_LANE_GAP_EN` defined: per-lane gap counters are compiled in, and eligibility requires gap=0.
- Not defined: gap counters are removed, eligibility is `lane_free` only, and `LANE_GAP` is unused.

## Test plan
- Reset, `start`, 120 ticks: `state` goes 1 then 2 on exactly the 120th tick. `speed`=1.
- Score=0, all lanes free, `spawn_ready`=1: `spawn_valid` pulses once every 200 ticks, one cycle after the tick.
- Score=100: period clamps to 40, `speed`=5. Score=40: period=40. Score=39: period=44.
- `rand[1:0]`=2 with `lane_free`=4'b1011: lane 3 is selected. With `lane_free`=0: no request and `skip_count` increments. Forcing 300 skips holds `skip_count` at 255.
- `spawn_ready`=0 for 50 cycles: `spawn_valid` and `spawn_lane` are stable throughout. Asserting `pause` meanwhile keeps `state`=2 until the transfer, then `state`=3.
- With `_EN` defined: two consecutive spawns seeded at lane 0 within 20 frames go to lanes 0 then 1. Without the macro: both go to lane 0.
